velocity_cell_mem_dbuf: RTL and testbench

Double-buffered, parametrised per-cell velocity memory, the successor of the single-port per-cell velocity RAMs. It holds two banks of `{vz, vy, vx}` words per cell. The motion-update unit reads current-step velocities from the read bank while writing next-step velocities into the write bank; a swap handshake exchanges the banks at the step boundary. It sits between the velocity cache and the motion-update pipeline, one instance per cell.

---
 rtl/velocity_cell_mem_dbuf.sv | 165 ++++++++++++++++
 tb/tb_velocity_cell_mem_dbuf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/velocity_cell_mem_dbuf.sv
// Double-buffered per-cell velocity memory: reads use bank bank_sel and writes use bank ~bank_sel, exchanged by a swap handshake.
// Latency: reads take 1 cycle. A swap takes 2 cycles, or PARTICLE_NUM+2 cycles when VEL_BANK_CLEAR_EN zeroes the new write bank.
// Backpressure: none. swap_req is ignored while busy, and external writes are dropped while the clear runs.
module velocity_cell_mem_dbuf #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic                  busy,
    output logic                  bank_sel,
    output logic                  addr_err
);

`ifdef VEL_BANK_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_SWAP, S_CLEAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SWAP} state_t;
`endif

    state_t                  state_q;
    logic                    bank_sel_q;
    logic                    busy_q;
    logic                    swap_done_q;
    logic                    addr_err_q;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    // Storage is deliberately left unreset so the arrays map onto block RAM.
    logic [DATA_WIDTH-1:0]   mem0 [0:PARTICLE_NUM-1];
    logic [DATA_WIDTH-1:0]   mem1 [0:PARTICLE_NUM-1];

    logic                    rd_oob;
    logic                    wr_oob;
    logic                    clearing;
    logic                    ext_wr;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

`ifdef VEL_BANK_CLEAR_EN
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    assign clearing = (state_q == S_CLEAR);
`else
    assign clearing = 1'b0;
`endif

    assign rd_oob = int'(rd_addr) >= PARTICLE_NUM;
    assign wr_oob = int'(wr_addr) >= PARTICLE_NUM;
    // External writes yield to the clear sweep. A write dropped during the clear is not an addressing error.
    assign ext_wr = wr_en && !clearing && !wr_oob;

    // Select the write source: the clear sweep when it is running, otherwise the external port.
    always_comb begin
        mem_we    = ext_wr;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
`ifdef VEL_BANK_CLEAR_EN
        if (clearing) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
        end
`endif
    end

    // Bank 0 is the write bank while bank 1 is being read.
    always_ff @(posedge clk) begin
        if (mem_we && bank_sel_q) mem0[mem_waddr] <= mem_wdata;
    end

    // Bank 1 is the write bank while bank 0 is being read.
    always_ff @(posedge clk) begin
        if (mem_we && !bank_sel_q) mem1[mem_waddr] <= mem_wdata;
    end

    // Registered read from the read bank. An out-of-range address still returns valid data, forced to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                if (rd_oob)          rd_data_q <= '0;
                else if (bank_sel_q) rd_data_q <= mem1[rd_addr];
                else                 rd_data_q <= mem0[rd_addr];
            end
        end
    end

    // Sticky out-of-range flag. Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else if ((rd_en && rd_oob) || (wr_en && !clearing && wr_oob)) begin
            addr_err_q <= 1'b1;
        end
    end

    // Swap FSM. busy stays high through the swap_done cycle, so a request in that cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bank_sel_q  <= 1'b0;
            busy_q      <= 1'b0;
            swap_done_q <= 1'b0;
`ifdef VEL_BANK_CLEAR_EN
            clr_cnt_q   <= '0;
`endif
        end else begin
            swap_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (swap_req && !busy_q) begin
                        state_q <= S_SWAP;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_SWAP: begin
                    bank_sel_q <= ~bank_sel_q;
`ifdef VEL_BANK_CLEAR_EN
                    state_q    <= S_CLEAR;
                    clr_cnt_q  <= '0;
`else
                    state_q     <= S_IDLE;
                    swap_done_q <= 1'b1;
`endif
                end
`ifdef VEL_BANK_CLEAR_EN
                S_CLEAR: begin
                    if (clr_cnt_q == ADDR_WIDTH'(PARTICLE_NUM - 1)) begin
                        state_q     <= S_IDLE;
                        swap_done_q <= 1'b1;
                        clr_cnt_q   <= '0;
                    end else begin
                        clr_cnt_q   <= clr_cnt_q + 1'b1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign swap_done = swap_done_q;
    assign busy      = busy_q;
    assign bank_sel  = bank_sel_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_velocity_cell_mem_dbuf.sv
// Testbench for velocity_cell_mem_dbuf. A scoreboard queue holds the expected read data.
// A monitor on the falling edge pops the queue and compares whenever rd_valid is high, and it counts swap_done pulses.
// Build-dependent expectations follow VEL_BANK_CLEAR_EN.
module tb_velocity_cell_mem_dbuf;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
`ifdef VEL_BANK_CLEAR_EN
    localparam int SWAP_LAT = PN + 2;
    localparam int RST_AT   = 50;
`else
    localparam int SWAP_LAT = 2;
    localparam int RST_AT   = 1;
`endif

    localparam logic [DW-1:0] V1   = 96'h00000003_00000002_00000001;
    localparam logic [DW-1:0] VAA  = 96'h000000AA;
    localparam logic [DW-1:0] V219 = 96'h00000219_00000219_00000219;
    localparam logic [DW-1:0] V9   = 96'h00000009_00000008_00000007;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap_req;
    logic          swap_done;
    logic          busy;
    logic          bank_sel;
    logic          addr_err;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            done_cnt = 0;
    int            exp_done = 0;
    logic          exp_bank = 1'b0;
    logic [DW-1:0] exp_q [$];

    velocity_cell_mem_dbuf #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .swap_req  (swap_req),
        .swap_done (swap_done),
        .busy      (busy),
        .bank_sel  (bank_sel),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_en = 1'b1; rd_addr = a;
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    // Issues one swap and measures the request-to-done latency. Optionally keeps swap_req high while busy,
    // and optionally drives writes (to addr 7 or out of range at addr 230) while the swap is running.
    task automatic do_swap(input bit hold, input bit wr_during);
        int k;
        bit busy_ok;
        bit seen;
        k = 0; busy_ok = 1'b1; seen = 1'b0;
        swap_req = 1'b1;
        while (!seen && k < 400) begin
            tick();
            k++;
            swap_req = hold;
            if (wr_during && k > 1) begin
                wr_en   = 1'b1;
                wr_addr = k[0] ? 8'd7 : 8'd230;
                wr_data = 96'h55;
            end
            if (!busy) busy_ok = 1'b0;
            if (swap_done) seen = 1'b1;
        end
        swap_req = 1'b0;
        wr_en    = 1'b0;
        chk("swap_latency", 96'(k), 96'(SWAP_LAT));
        chk("busy_during_swap", 96'(busy_ok), 96'(1));
        exp_bank = ~exp_bank;
        exp_done++;
        chk("bank_sel_after_swap", 96'(bank_sel), 96'(exp_bank));
        tick();
        chk("busy_after_done", 96'(busy), 96'(0));
        chk("swap_done_single", 96'(swap_done), 96'(0));
        chk("bank_sel_stable", 96'(bank_sel), 96'(exp_bank));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_data"},   rd_data,           96'(0));
        chk({tag, "_rd_valid"},  96'(rd_valid),     96'(0));
        chk({tag, "_swap_done"}, 96'(swap_done),    96'(0));
        chk({tag, "_busy"},      96'(busy),         96'(0));
        chk({tag, "_bank_sel"},  96'(bank_sel),     96'(0));
        chk({tag, "_addr_err"},  96'(addr_err),     96'(0));
    endtask

    // Monitor: the scoreboard compare for read data, and the swap_done pulse counter.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (rd_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rd_valid", 96'(rd_valid), 96'(0));
                    end else begin
                        chk("rd_data", rd_data, exp_q.pop_front());
                    end
                end
                if (swap_done === 1'b1) done_cnt++;
            end
        end
    end

    // Watchdog that bounds the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp4;
`ifdef VEL_BANK_CLEAR_EN
        exp4 = '0;
`else
        exp4 = V1;
`endif
        rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; swap_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Write, swap, then read the written word back.
        do_write(8'd5, V1);
        chk("addr_err_clean", 96'(addr_err), 96'(0));
        do_swap(1'b0, 1'b0);
        do_read(8'd5, V1);
        tick();
        chk("rd_valid_idle", 96'(rd_valid), 96'(0));
        chk("rd_data_hold", rd_data, V1);

        // A read and a write to the same address in the same cycle: the read sees the old value.
        rd_en = 1'b1; rd_addr = 8'd5; wr_en = 1'b1; wr_addr = 8'd5; wr_data = VAA;
        exp_q.push_back(V1);
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        do_write(8'd219, V219);
        chk("addr_err_last_addr", 96'(addr_err), 96'(0));
        do_swap(1'b0, 1'b0);
        do_read(8'd5, VAA);
        do_read(8'd219, V219);

        // Out-of-range write and read in the same cycle.
        rd_en = 1'b1; rd_addr = 8'd255; wr_en = 1'b1; wr_addr = 8'd220; wr_data = 96'hDEAD;
        exp_q.push_back('0);
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        chk("addr_err_set", 96'(addr_err), 96'(1));
        repeat (3) tick();
        chk("addr_err_sticky", 96'(addr_err), 96'(1));

        // Keep swap_req high while busy: expect exactly one bank exchange.
        do_swap(1'b1, 1'b0);
        chk("addr_err_after_swap", 96'(addr_err), 96'(1));
        do_read(8'd5, exp4);

        // Reset in the middle of a swap or clear.
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        repeat (RST_AT - 1) tick();
        chk("busy_before_reset", 96'(busy), 96'(1));
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midswap_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_bank = 1'b0;
        tick();
        chk("swap_done_after_reset", 96'(swap_done), 96'(0));

        // After reset, a normal write and swap still work.
        do_write(8'd9, V9);
        do_swap(1'b0, 1'b0);
        do_read(8'd9, V9);

`ifdef VEL_BANK_CLEAR_EN
        // Writes during the clear are dropped and raise no error. The next swap exposes a fully zeroed bank.
        do_swap(1'b0, 1'b1);
        chk("addr_err_clear_wr", 96'(addr_err), 96'(0));
        do_swap(1'b0, 1'b0);
        do_read(8'd0, '0);
        do_read(8'd5, '0);
        do_read(8'd7, '0);
        do_read(8'd9, '0);
        do_read(8'd219, '0);
`endif

        repeat (2) tick();
        chk("scoreboard_drained", 96'(exp_q.size()), 96'(0));
        chk("swap_done_count", 96'(done_cnt), 96'(exp_done));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
